// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared state encoding and frame constants for the debug frame sender
package debug_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_WORDS      = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LATCH   = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4,
        DONE    = 3'd5
    } state_t;
endpackage

// File: rtl/debug_word_serializer.sv
// rtl/debug_word_serializer.sv - 32-bit word to MSB-first byte serializer
module debug_word_serializer
    import debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_shift,
    output logic [7:0]  o_tx_data,
    output logic        o_last
);
    localparam int BYTE_CNT_W = $clog2(BYTES_PER_WORD);

    logic [31:0]           r_shift;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_load) begin
            r_shift    <= i_word;
            r_byte_cnt <= '0;
        end else if (i_shift) begin
            r_shift    <= {r_shift[23:0], 8'h00};
            r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
        end
    end

    assign o_tx_data = r_shift[31:24];
    assign o_last    = (r_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/debug_frame_sender.sv
// rtl/debug_frame_sender.sv - snapshots count/pc and streams count, pc, regs and memory to the UART
module debug_frame_sender
    import debug_pkg::*;
#(
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 16,
    parameter int MEM_ADDR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_start_send,
    input  logic [31:0]           i_clk_count,
    input  logic [31:0]           i_pc,
    output logic [4:0]            o_reg_addr,
    input  logic [31:0]           i_reg_data,
    output logic [MEM_ADDR_W-1:0] o_mem_addr,
    input  logic [31:0]           i_mem_data,
    output logic [7:0]            o_tx_data,
    output logic                  os_tx_start,
    input  logic                  is_tx_done,
    output logic                  os_done_send
);
    localparam int TOTAL = HDR_WORDS + N_REGS + N_MEM_WORDS;
    // Two spare bits over the widest address guarantee TOTAL fits for any legal parameter set.
    localparam int IDX_W = ((MEM_ADDR_W > 5) ? MEM_ADDR_W : 5) + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
    localparam logic [IDX_W-1:0] REG_BASE = IDX_W'(HDR_WORDS);
    localparam logic [IDX_W-1:0] MEM_BASE = IDX_W'(HDR_WORDS + N_REGS);

    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_word_idx;
    logic [31:0]       r_shadow_cnt;
    logic [31:0]       r_shadow_pc;
    logic [31:0]       w_word;
    logic              w_in_regs;
    logic              w_in_mem;
    logic              w_done_ok;
    logic              w_last;

    assign w_in_regs  = (r_word_idx >= REG_BASE) && (r_word_idx < MEM_BASE);
    assign w_in_mem   = (r_word_idx >= MEM_BASE);
    assign o_reg_addr = w_in_regs ? 5'(r_word_idx - REG_BASE) : '0;
    assign o_mem_addr = w_in_mem ? MEM_ADDR_W'(r_word_idx - MEM_BASE) : '0;
    assign w_done_ok  = (r_state == WAIT_TX) && is_tx_done;

    always_comb begin
        w_word = i_mem_data;
        if (r_word_idx == IDX_W'(0))
            w_word = r_shadow_cnt;
        else if (r_word_idx == IDX_W'(1))
            w_word = r_shadow_pc;
        else if (w_in_regs)
            w_word = i_reg_data;
    end

    debug_word_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_state == LATCH),
        .i_word    (w_word),
        .i_shift   (w_done_ok && !w_last),
        .o_tx_data (o_tx_data),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        os_tx_start  = 1'b0;
        os_done_send = 1'b0;
        case (r_state)
            IDLE:    if (is_start_send) w_next_state = FETCH;
            FETCH:   w_next_state = LATCH;
            LATCH:   w_next_state = SEND;
            SEND: begin
                os_tx_start  = 1'b1;
                w_next_state = WAIT_TX;
            end
            WAIT_TX: begin
                if (is_tx_done) begin
                    if (!w_last)
                        w_next_state = SEND;
                    else if (r_word_idx == LAST_IDX)
                        w_next_state = DONE;
                    else
                        w_next_state = FETCH;
                end
            end
            DONE: begin
                os_done_send = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_idx   <= '0;
            r_shadow_cnt <= '0;
            r_shadow_pc  <= '0;
        end else if (r_state == IDLE && is_start_send) begin
            r_word_idx   <= '0;
            r_shadow_cnt <= i_clk_count;
            r_shadow_pc  <= i_pc;
        end else if (w_done_ok && w_last && r_word_idx != LAST_IDX) begin
            r_word_idx <= r_word_idx + IDX_W'(1);
        end
    end
endmodule

// File: tb/tb_debug_frame_sender.sv
// tb/tb_debug_frame_sender.sv - directed bench for debug_frame_sender
module tb_debug_frame_sender;
    typedef struct {
        logic [31:0] cnt;
        logic [31:0] pc;
        logic [31:0] cnt_after;
        bit          rnd;
        bit          poke;
        logic [63:0] exp_hdr;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        d_start, d_tx_start, d_tx_done, d_done;
    logic [31:0] d_cnt, d_pc, d_reg_data, d_mem_data;
    logic [4:0]  d_reg_addr;
    logic [3:0]  d_mem_addr;
    logic [7:0]  d_tx_data;

    logic        m_start, m_tx_start, m_tx_done, m_done;
    logic [31:0] m_cnt, m_pc, m_reg_data, m_mem_data;
    logic [4:0]  m_reg_addr;
    logic [0:0]  m_mem_addr;
    logic [7:0]  m_tx_data;

    debug_frame_sender dut (
        .clk(clk), .rst(rst), .is_start_send(d_start), .i_clk_count(d_cnt), .i_pc(d_pc),
        .o_reg_addr(d_reg_addr), .i_reg_data(d_reg_data), .o_mem_addr(d_mem_addr),
        .i_mem_data(d_mem_data), .o_tx_data(d_tx_data), .os_tx_start(d_tx_start),
        .is_tx_done(d_tx_done), .os_done_send(d_done)
    );

    debug_frame_sender #(.N_REGS(1), .N_MEM_WORDS(1), .MEM_ADDR_W(1)) dut_min (
        .clk(clk), .rst(rst), .is_start_send(m_start), .i_clk_count(m_cnt), .i_pc(m_pc),
        .o_reg_addr(m_reg_addr), .i_reg_data(m_reg_data), .o_mem_addr(m_mem_addr),
        .i_mem_data(m_mem_data), .o_tx_data(m_tx_data), .os_tx_start(m_tx_start),
        .is_tx_done(m_tx_done), .os_done_send(m_done)
    );

    int checks = 0;
    int failures = 0;
    int addr_err, stab_err, d_starts, d_dones, m_dones;
    int stray_at = -1;
    bit d_rand = 0;
    logic [7:0] dq[$];
    logic [7:0] mq[$];

    function automatic logic [31:0] reg_val(input logic [4:0] a);
        return 32'hA000_0000 + 32'(a) * 32'h0001_0101;
    endfunction

    function automatic logic [31:0] mem_val(input logic [3:0] a);
        return 32'hC0DE_0000 + 32'(a) * 32'h0000_0011;
    endfunction

    function automatic logic [31:0] exp_word(input int w, input logic [31:0] c, input logic [31:0] p);
        if (w == 0) return c;
        if (w == 1) return p;
        if (w < 34) return reg_val(5'(w - 2));
        return mem_val(4'(w - 34));
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Synchronous-read memories: data in cycle n+1 reflects the address of cycle n.
    initial begin
        logic [4:0] ra, mra;
        logic [3:0] ma;
        logic [0:0] mma;
        d_reg_data = '0; d_mem_data = '0; m_reg_data = '0; m_mem_data = '0;
        forever begin
            @(negedge clk);
            ra = d_reg_addr; ma = d_mem_addr; mra = m_reg_addr; mma = m_mem_addr;
            @(posedge clk);
            #1;
            d_reg_data = reg_val(ra);
            d_mem_data = mem_val(ma);
            m_reg_data = (mra == 5'd0) ? 32'h0102_0304 : 32'h0;
            m_mem_data = (mma == 1'b0) ? 32'hDEAD_BEEF : 32'h0;
        end
    end

    initial begin
        logic [7:0] b;
        int w, er, em, dly;
        d_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            d_tx_done = 1'b0;
            if (d_tx_start) begin
                b  = d_tx_data;
                w  = dq.size() / 4;
                er = (w >= 2 && w < 34) ? w - 2 : 0;
                em = (w >= 34) ? w - 34 : 0;
                if (d_reg_addr !== 5'(er) || d_mem_addr !== 4'(em)) addr_err++;
                dq.push_back(b);
                d_starts++;
                if (dq.size() == stray_at) d_tx_done = 1'b1;
                dly = d_rand ? int'($urandom_range(1, 20)) : 2;
                for (int k = 0; k < dly; k++) begin
                    @(negedge clk);
                    d_tx_done = (k == dly - 1);
                    if (!rst && d_tx_data !== b) stab_err++;
                end
            end
        end
    end

    initial begin
        m_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            m_tx_done = 1'b0;
            if (m_tx_start) begin
                mq.push_back(m_tx_data);
                @(negedge clk);
                @(negedge clk);
                m_tx_done = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (d_done) d_dones++;
            if (m_done) m_dones++;
        end
    end

    task automatic run_frame(input frame_t v, input string tag);
        int lat, n, errs;
        logic [63:0] hdr;
        logic [31:0] ww;
        dq.delete();
        addr_err = 0; stab_err = 0; d_dones = 0;
        d_rand = v.rnd;
        stray_at = v.poke ? 13 : -1;
        @(negedge clk);
        d_cnt = v.cnt; d_pc = v.pc; d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0; d_cnt = v.cnt_after; d_pc = ~v.pc;
        lat = 1;
        while (!d_tx_start && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(3));
        if (v.poke) begin
            n = 0;
            while (dq.size() < 10 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            d_start = 1'b1;
            @(negedge clk);
            d_start = 1'b0;
        end
        n = 0;
        while (d_dones == 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_in_time"}, 128'(n < 20000), 128'(1));
        repeat (40) @(negedge clk);
        check({tag, "_done_pulses"}, 128'(d_dones), 128'(1));
        check({tag, "_byte_count"}, 128'(dq.size()), 128'(200));
        hdr = '0;
        for (int i = 0; i < 8; i++)
            if (i < dq.size()) hdr = {hdr[55:0], dq[i]};
        check({tag, "_header"}, 128'(hdr), 128'(v.exp_hdr));
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            ww = exp_word(i / 4, v.cnt, v.pc);
            if (i >= dq.size() || dq[i] !== ww[8*(3-(i%4)) +: 8]) errs++;
        end
        check({tag, "_byte_errors"}, 128'(errs), 128'(0));
        check({tag, "_addr_errors"}, 128'(addr_err), 128'(0));
        check({tag, "_stable_errors"}, 128'(stab_err), 128'(0));
    endtask

    frame_t frames[4];

    initial begin
        int lat, n, starts_before;
        logic [127:0] mbytes;

        frames[0] = '{cnt: 32'h0000_0005, pc: 32'h0000_0100, cnt_after: 32'h0000_0009, rnd: 0, poke: 0, exp_hdr: 64'h00000005_00000100};
        frames[1] = '{cnt: 32'h1234_5678, pc: 32'h8000_0040, cnt_after: 32'h1234_5679, rnd: 1, poke: 0, exp_hdr: 64'h12345678_80000040};
        frames[2] = '{cnt: 32'h0000_0005, pc: 32'hCAFE_F00D, cnt_after: 32'h0000_0009, rnd: 1, poke: 1, exp_hdr: 64'h00000005_CAFEF00D};
        frames[3] = '{cnt: 32'hFFFF_FFFF, pc: 32'h0000_0000, cnt_after: 32'h0000_0000, rnd: 0, poke: 1, exp_hdr: 64'hFFFFFFFF_00000000};

        rst = 1'b1;
        d_start = 1'b0; d_cnt = '0; d_pc = '0;
        m_start = 1'b0; m_cnt = '0; m_pc = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 128'({d_tx_start, d_done, d_tx_data, d_reg_addr, d_mem_addr}), 128'(0));
        rst = 1'b0;

        // Minimal-frame instance with fixed two-cycle UART turnaround.
        @(negedge clk);
        m_cnt = 32'h0000_0011; m_pc = 32'hAABB_CCDD; m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0; m_cnt = 32'h0; m_pc = 32'h0;
        lat = 1;
        while (!m_tx_start && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("min_latency", 128'(lat), 128'(3));
        n = 0;
        while (m_dones == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check("min_done_pulses", 128'(m_dones), 128'(1));
        check("min_byte_count", 128'(mq.size()), 128'(16));
        mbytes = '0;
        for (int i = 0; i < 16; i++)
            if (i < mq.size()) mbytes = {mbytes[119:0], mq[i]};
        check("min_bytes", mbytes, 128'h00000011_AABBCCDD_01020304_DEADBEEF);

        for (int f = 0; f < 4; f++)
            run_frame(frames[f], $sformatf("frame%0d", f));

        // Reset in the middle of the 7th byte's WAIT_TX.
        dq.delete();
        d_rand = 0; stray_at = -1; d_dones = 0;
        @(negedge clk);
        d_cnt = 32'h0000_0077; d_pc = 32'h0000_0200; d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        n = 0;
        while (dq.size() < 7 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reached_byte7", 128'(dq.size()), 128'(7));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_async_outputs", 128'({d_tx_start, d_done, d_tx_data, d_reg_addr, d_mem_addr}), 128'(0));
        starts_before = d_starts;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_no_more_starts", 128'(d_starts), 128'(starts_before));
        check("midrst_no_done", 128'(d_dones), 128'(0));
        run_frame(frames[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/debug_frame_sender.md
Name: debug_frame_sender

Overview:
- Downstream consumer of the fast-run controller's `os_start_send` / `o_clk_count`; it returns `os_done_send` to that controller.
- On a start pulse it snapshots the cycle count and PC, then walks the register file and data memory debug read ports.
- It serialises every 32-bit word, MSB byte first, into the UART transmitter via a start/done byte handshake.
- Frame layout, in order: clk_count, pc, regs[0..N_REGS-1], mem[0..N_MEM_WORDS-1].

Parameters:
- N_REGS, 32, number of register-file words sent (1..32).
- N_MEM_WORDS, 16, number of data-memory words sent (1..2**MEM_ADDR_W).
- MEM_ADDR_W, 4, width of the memory debug word address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- is_start_send  in  1  request to send a frame; sampled only in IDLE.
- i_clk_count  in  32  cycle count from the fast-run controller.
- i_pc  in  32  current program counter.
- o_reg_addr  out  5  register-file debug read address.
- i_reg_data  in  32  register data; valid 1 cycle after o_reg_addr.
- o_mem_addr  out  MEM_ADDR_W  memory debug word address.
- i_mem_data  in  32  memory data; valid 1 cycle after o_mem_addr.
- o_tx_data  out  8  byte to the UART transmitter.
- os_tx_start  out  1  1-cycle pulse: UART, send o_tx_data.
- is_tx_done  in  1  UART finished the current byte (pulse).
- os_done_send  out  1  1-cycle pulse: frame complete.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; shadow regs, shift reg, word_idx and byte_cnt cleared.
- Output decoding: os_tx_start and os_done_send are Moore outputs decoded from state.
- Word index: word_idx spans 0..TOTAL-1, with TOTAL = 2+N_REGS+N_MEM_WORDS.
- Read addresses:
  - o_reg_addr = word_idx-2 when 2 ≤ idx < 2+N_REGS, else 0.
  - o_mem_addr = word_idx-2-N_REGS when idx ≥ 2+N_REGS, else 0.
- IDLE:
  - On is_start_send=1: capture i_clk_count and i_pc into shadow regs, set word_idx=0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: drive the read addresses for word_idx (1 cycle) -> LATCH.
- LATCH:
  - Load the 32-bit shift reg from: shadow count (idx 0), shadow pc (idx 1), i_reg_data, or i_mem_data.
  - Set byte_cnt=0 -> SEND.
- SEND: os_tx_start=1 for exactly one cycle; o_tx_data = shift[31:24] -> WAIT_TX.
- WAIT_TX: hold o_tx_data stable; wait for is_tx_done.
  - On done with byte_cnt<3: shift left by 8, byte_cnt+1 -> SEND.
  - On done with byte_cnt=3 and word_idx=TOTAL-1 -> DONE.
  - On done with byte_cnt=3 otherwise: word_idx+1 -> FETCH.
- DONE: os_done_send=1 for one cycle -> IDLE.
- Latency: the first os_tx_start occurs 3 cycles after is_start_send is sampled.
- Frame length: exactly 4*TOTAL bytes and 4*TOTAL os_tx_start pulses.
- Start while busy: is_start_send outside IDLE is ignored; no queuing.
- Stray done: is_tx_done outside WAIT_TX is ignored.
- is_tx_done in the same cycle as SEND is ignored; only WAIT_TX samples it.
- Snapshot: changes on i_clk_count / i_pc after the start cycle do not affect the frame.
- Reset mid-frame: immediate return to IDLE, os_tx_start=0, os_done_send not issued.
- Illegal state encodings: return to IDLE with all outputs 0.

Decomposition:
- Shared package debug_pkg holds:
  - the state encoding: IDLE, FETCH, LATCH, SEND, WAIT_TX, DONE (3 bits);
  - BYTES_PER_WORD=4;
  - the header word count HDR_WORDS=2.
- One sub-module, debug_word_serializer, owns the 32-bit shift reg, byte_cnt, o_tx_data and the last-byte flag.
  - Inputs: load, word, shift.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 asynchronously; start pulse after release -> first os_tx_start 3 cycles later.
- Minimal frame (N_REGS=1, N_MEM_WORDS=1):
  - Stimulus: clk_count=0x00000011, pc=0xAABBCCDD, reg0=0x01020304, mem0=0xDEADBEEF, tx_done 2 cycles after each start.
  - Required bytes: 00 00 00 11 AA BB CC DD 01 02 03 04 DE AD BE EF.
  - Then one os_done_send pulse.
- Default parameters, random UART delays of 1..20 cycles:
  - Exactly 200 os_tx_start pulses.
  - o_reg_addr steps 0..31, o_mem_addr steps 0..15.
  - o_tx_data stable throughout each WAIT_TX.
- Busy robustness:
  - Pulse is_start_send and a stray is_tx_done mid-frame -> byte stream unchanged, no second frame.
  - Change i_clk_count from 5 to 9 after the start cycle -> bytes still encode 5.
- Reset mid-frame:
  - Assert rst during the 7th byte's WAIT_TX -> no further os_tx_start, no os_done_send.
  - New start after release -> full frame beginning with the clk_count MSB.
